// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core load/store
// path (port A) and a DMA/debug requester (port B). Each accepted request becomes
// one BUSY cycle with a memory strobe, then one RESP cycle with a done pulse.
// Illegal accesses (misaligned or beyond the last word) are rejected without a strobe.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: port A always wins ties, no round-robin state.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_done,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_done,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic        win_q, win_d;       // 1 = port B owns the current access
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    logic        any_req;
    logic        sel_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rd_capture;
    logic        busy_ok;

    assign any_req = a_req | b_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Fixed priority: B only wins when A is not asking.
    always_comb sel_b = b_req & ~a_req;
`else
    logic last_q, last_d;            // 1 = B was granted last; resets to B so A wins the first tie

    // Round-robin: on a tie the port that was not granted last wins.
    always_comb sel_b = b_req & (~a_req | ~last_q);

    // Remember the most recent winner at each acceptance.
    always_comb last_d = (state_q == IDLE && any_req) ? sel_b : last_q;

    // Round-robin history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    // Mux the winning port's request fields.
    always_comb begin
        sel_we    = sel_b ? b_we    : a_we;
        sel_addr  = sel_b ? b_addr  : a_addr;
        sel_wdata = sel_b ? b_wdata : a_wdata;
    end

    // Grants are only offered in IDLE; the inputs are latched on the same edge.
    assign a_gnt = (state_q == IDLE) && a_req && !sel_b;
    assign b_gnt = (state_q == IDLE) && sel_b;

    // Rejected accesses return zero instead of whatever the memory drives.
    assign rd_capture = err_q ? 32'h0 : mem_rdata;

    // Sequencer next-state: accept in IDLE, strobe in BUSY, respond in RESP.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    win_d   = sel_b;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
                end
            end
            BUSY: begin
                state_d = RESP;
                // Good writes leave rdata alone; reads and rejects update it.
                if (err_q || !we_q) begin
                    if (win_q) b_rdata_d = rd_capture;
                    else       a_rdata_d = rd_capture;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            a_rdata_q <= 32'h0;
            b_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Memory strobes come straight from the state flop so reset kills them at once.
    assign busy_ok   = (state_q == BUSY) && !err_q;
    assign mem_we    = busy_ok && we_q;
    assign mem_re    = busy_ok && !we_q;
    assign mem_addr  = busy_ok ? addr_q : 32'h0;
    assign mem_wdata = (busy_ok && we_q) ? wdata_q : 32'h0;

    assign a_done  = (state_q == RESP) && !win_q;
    assign b_done  = (state_q == RESP) && win_q;
    assign a_err   = a_done && err_q;
    assign b_err   = b_done && err_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives both ports of dmem_arbiter against a simple word memory
// and compares every response with a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int unsigned MEM_BYTES = 65536;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory behind the arbiter: combinational read, write at the edge.
    logic [31:0] mem [0:16383];
    logic        mem_clr;
    assign mem_rdata = mem_re ? mem[mem_addr[15:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
        end else if (mem_we) begin
            mem[mem_addr[15:2]] <= mem_wdata;
        end
    end

    // Reference model: memory contents, per-port last read data, last winner.
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] m_rdata [2];
    bit          m_last;                 // 1 = B
    int          checks = 0;
    int          failures = 0;

    function automatic bit m_err(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr > MEM_BYTES - 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        return ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    endfunction

    // Winner of a request set: a lone requester wins; ties follow the policy.
    function automatic bit m_winner(input bit ar, input bit br);
        if (!br) return 1'b0;
        if (!ar) return 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return !m_last;
`endif
    endfunction

    task automatic m_apply(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        m_last = port;
        if (m_err(addr))  m_rdata[port] = 32'h0;
        else if (we)      ref_mem[addr] = wdata;
        else              m_rdata[port] = m_read(addr);
    endtask

    task automatic m_reset;
        m_last = 1'b1;
        m_rdata[0] = 32'h0;
        m_rdata[1] = 32'h0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; end
        else      begin a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; end
    endtask

    // Runs one single-port access: waits (bounded) for grant, then watches 4 cycles.
    task automatic run_one(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int gnt_wait, output int done_lat, output logic err,
                           output logic [31:0] rdata, output int we_cnt, output int re_cnt);
        gnt_wait = -1; done_lat = -1; err = 1'b0; rdata = 32'h0; we_cnt = 0; re_cnt = 0;
        drive(port, 1'b1, we, addr, wdata);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (port ? b_gnt : a_gnt) begin gnt_wait = c; break; end
            tick();
        end
        tick();
        drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
        if (gnt_wait < 0) return;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (mem_we) we_cnt++;
            if (mem_re) re_cnt++;
            if ((port ? b_done : a_done) && done_lat < 0) begin
                done_lat = k;
                err      = port ? b_err : a_err;
                rdata    = port ? b_rdata : a_rdata;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_clr = 1'b1;
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_we, mem_re} !== 8'h0 ||
            {a_rdata, b_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_hold: outputs not all zero during reset");
        end
        rst_n = 1'b1; mem_clr = 1'b0;
        tick(); #1;
        checks++;
        if ({a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_we, mem_re} !== 8'h0 ||
            {a_rdata, b_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_release: outputs not all zero after release");
        end
        tick();
    endtask

    task automatic test_write_read;
        int gw, dl, wc, rc; logic e; logic [31:0] rd;
        run_one(0, 1, 32'h100, 32'hDEADBEEF, gw, dl, e, rd, wc, rc);
        m_apply(0, 1, 32'h100, 32'hDEADBEEF);
        checks++; if (gw !== 0) begin failures++; $display("FAIL wr_gnt: wait %0d expected 0", gw); end
        checks++; if (dl !== 2) begin failures++; $display("FAIL wr_done_lat: got %0d expected 2", dl); end
        checks++; if (wc !== 1 || rc !== 0) begin failures++; $display("FAIL wr_strobe: we=%0d re=%0d expected 1/0", wc, rc); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr_err: got %b expected 0", e); end
        run_one(0, 0, 32'h100, 32'h0, gw, dl, e, rd, wc, rc);
        m_apply(0, 0, 32'h100, 32'h0);
        checks++; if (dl !== 2) begin failures++; $display("FAIL rd_done_lat: got %0d expected 2", dl); end
        checks++; if (wc !== 0 || rc !== 1) begin failures++; $display("FAIL rd_strobe: we=%0d re=%0d expected 0/1", wc, rc); end
        checks++; if (rd !== m_rdata[0] || e !== 1'b0) begin
            failures++;
            $display("FAIL rd_data: got %h err %b expected %h err 0", rd, e, m_rdata[0]);
        end
    endtask

    task automatic test_range;
        logic [31:0] addrs [3];
        int gw, dl, wc, rc; logic e; logic [31:0] rd;
        addrs[0] = 32'h102; addrs[1] = 32'hFFFC; addrs[2] = 32'h10000;
        for (int i = 0; i < 3; i++) begin
            run_one(1, 0, addrs[i], 32'h0, gw, dl, e, rd, wc, rc);
            m_apply(1, 0, addrs[i], 32'h0);
            checks++;
            if (e !== m_err(addrs[i]) || dl !== 2) begin
                failures++;
                $display("FAIL range_err[%0d]: err %b lat %0d expected err %b lat 2", i, e, dl, m_err(addrs[i]));
            end
            checks++;
            if (rc !== (m_err(addrs[i]) ? 0 : 1) || wc !== 0) begin
                failures++;
                $display("FAIL range_strobe[%0d]: re=%0d we=%0d", i, rc, wc);
            end
            checks++;
            if (rd !== m_rdata[1]) begin
                failures++;
                $display("FAIL range_rdata[%0d]: got %h expected %h", i, rd, m_rdata[1]);
            end
        end
    endtask

    // Both ports keep requesting; grant order must follow the arbitration policy.
    task automatic test_tie;
        bit exp_p = 1'b0;
        drive(0, 1, 0, 32'h100, 0);
        drive(1, 1, 0, 32'h104, 0);
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (c % 3 == 0) begin
                exp_p = m_winner(1, 1);
                if ({a_gnt, b_gnt} !== (exp_p ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL tie_gnt@%0d: a=%b b=%b expected port %s", c, a_gnt, b_gnt, exp_p ? "B" : "A");
                end
                m_apply(exp_p, 0, exp_p ? 32'h104 : 32'h100, 0);
            end else if ((a_gnt | b_gnt) !== 1'b0) begin
                failures++;
                $display("FAIL tie_idle@%0d: unexpected grant a=%b b=%b", c, a_gnt, b_gnt);
            end
            if (c % 3 == 2) begin
                checks++;
                if ((exp_p ? {b_done, b_rdata} : {a_done, a_rdata}) !== {1'b1, m_rdata[exp_p]}) begin
                    failures++;
                    $display("FAIL tie_done@%0d: got done a=%b b=%b expected data %h", c, a_done, b_done, m_rdata[exp_p]);
                end
            end
            tick();
        end
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    endtask

    // Simultaneous write (A) and read (B) of one address: read sees the write.
    task automatic test_raw;
        int ag = -1, bg = -1, bd = -1;
        logic [31:0] brd = 32'h0, wd;
        bit first;
        wd = $urandom;
        first = m_winner(1, 1);
        drive(0, 1, 1, 32'h200, wd);
        drive(1, 1, 0, 32'h200, 0);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (a_gnt && ag < 0) ag = c;
            if (b_gnt && bg < 0) bg = c;
            if (b_done && bd < 0) begin bd = c; brd = b_rdata; end
            tick();
            if (ag >= 0) a_req = 1'b0;
            if (bg >= 0) b_req = 1'b0;
        end
        if (first) begin m_apply(1, 0, 32'h200, 0); m_apply(0, 1, 32'h200, wd); end
        else       begin m_apply(0, 1, 32'h200, wd); m_apply(1, 0, 32'h200, 0); end
        checks++; if (ag !== (first ? 3 : 0)) begin failures++; $display("FAIL raw_a_gnt: cycle %0d", ag); end
        checks++; if (bg !== (first ? 0 : 3)) begin failures++; $display("FAIL raw_b_gnt: cycle %0d", bg); end
        checks++; if (bd !== bg + 2) begin failures++; $display("FAIL raw_b_done: cycle %0d expected %0d", bd, bg + 2); end
        checks++; if (brd !== m_rdata[1]) begin failures++; $display("FAIL raw_b_rdata: got %h expected %h", brd, m_rdata[1]); end
    endtask

    // B holds req for 10 cycles alone: grants every third cycle.
    task automatic test_b_hold;
        int ngnt = 0, ndone = 0;
        drive(1, 1, 0, 32'h100, 0);
        for (int c = 0; c < 13; c++) begin
            #1;
            checks++;
            if (b_gnt !== (c < 10 && c % 3 == 0) || a_gnt !== 1'b0) begin
                failures++;
                $display("FAIL hold_gnt@%0d: b_gnt=%b a_gnt=%b", c, b_gnt, a_gnt);
            end
            if (b_gnt) begin ngnt++; m_apply(1, 0, 32'h100, 0); end
            if (b_done) begin
                ndone++;
                checks++;
                if (b_rdata !== m_rdata[1] || b_err !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_rdata@%0d: got %h expected %h", c, b_rdata, m_rdata[1]);
                end
            end
            tick();
            if (c == 9) b_req = 1'b0;
        end
        checks++;
        if (ngnt !== 4 || ndone !== 4) begin
            failures++;
            $display("FAIL hold_count: gnt %0d done %0d expected 4/4", ngnt, ndone);
        end
    endtask

    task automatic test_random;
        int gw, dl, wc, rc; logic e; logic [31:0] rd, addr, wd;
        bit port, we;
        for (int i = 0; i < 24; i++) begin
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            case ($urandom_range(0, 5))
                0:       addr = 32'h400 + 32'($urandom_range(1, 3));
                1:       addr = 32'h10000 + 32'($urandom_range(0, 15) * 4);
                default: addr = 32'h400 + 32'($urandom_range(0, 15) * 4);
            endcase
            run_one(port, we, addr, wd, gw, dl, e, rd, wc, rc);
            m_apply(port, we, addr, wd);
            checks++;
            if (gw !== 0 || dl !== 2 || e !== m_err(addr)) begin
                failures++;
                $display("FAIL rnd_resp[%0d]: gnt %0d lat %0d err %b expected 0/2/%b", i, gw, dl, e, m_err(addr));
            end
            checks++;
            if (wc !== ((we && !m_err(addr)) ? 1 : 0) || rc !== ((!we && !m_err(addr)) ? 1 : 0)) begin
                failures++;
                $display("FAIL rnd_strobe[%0d]: we=%0d re=%0d", i, wc, rc);
            end
            checks++;
            if (rd !== m_rdata[port] || (port ? a_rdata : b_rdata) !== m_rdata[!port]) begin
                failures++;
                $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, rd, m_rdata[port]);
            end
        end
    endtask

    // Reset pulsed in the BUSY cycle of a write.
    task automatic test_reset_busy;
        int gw, dl, wc, rc; logic e; logic [31:0] rd;
        drive(0, 1, 1, 32'h300, 32'h12345678);
        #1;
        checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL rb_gnt: got %b expected 1", a_gnt); end
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rb_busy_we: got %b expected 1", mem_we); end
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rb_we_drop: got %b expected 0", mem_we); end
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            checks++;
            if ({a_gnt, b_gnt, a_done, b_done, a_err, b_err, mem_we, mem_re} !== 8'h0 ||
                {a_rdata, b_rdata, mem_addr, mem_wdata} !== 128'h0) begin
                failures++;
                $display("FAIL rb_outputs@%0d: outputs not at reset values", c);
            end
        end
        tick();
        rst_n = 1'b1;
        tick(); #1;
        checks++;
        if (a_done !== 1'b0 || a_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rb_no_done: done %b rdata %h", a_done, a_rdata);
        end
        tick();
        run_one(0, 0, 32'h100, 32'h0, gw, dl, e, rd, wc, rc);
        m_apply(0, 0, 32'h100, 32'h0);
        checks++;
        if (dl !== 2 || rd !== m_rdata[0]) begin
            failures++;
            $display("FAIL rb_after: lat %0d data %h expected 2/%h", dl, rd, m_rdata[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_range();
        test_tie();
        test_raw();
        test_b_hold();
        test_random();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the 64 KiB byte-addressed data memory. It shares the single memory port between the core load/store path (port A) and a DMA/debug requester (port B) using a request/grant/done handshake. It converts each accepted request into a one-cycle memory strobe and returns read data with a completion pulse. It also rejects misaligned or out-of-range accesses before they reach the memory.

## Interface

- `MEM_BYTES`, 65536: memory size in bytes; last legal word address is `MEM_BYTES-4`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_req` / `b_req`  in  1  access request; held until grant.
- `a_we` / `b_we`  in  1  1 = word write, 0 = word read.
- `a_addr` / `b_addr`  in  32  byte address.
- `a_wdata` / `b_wdata`  in  32  write data.
- `a_gnt` / `b_gnt`  out  1  one-cycle pulse: request accepted, inputs sampled this edge.
- `a_done` / `b_done`  out  1  one-cycle completion pulse.
- `a_err` / `b_err`  out  1  valid with done; 1 = access rejected.
- `a_rdata` / `b_rdata`  out  32  read data, valid with done.
- `mem_we`  out  1  to memory MemWrite.
- `mem_re`  out  1  to memory MemRead.
- `mem_addr`  out  32  to memory address.
- `mem_wdata`  out  32  to memory writeData.
- `mem_rdata`  in  32  from memory readData (combinational, same cycle).

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req, select winner, assert its gnt, latch addr, we and wdata, and go to BUSY. Otherwise stay.
- Arbitration (default): round-robin. `last` register records the last-granted port and resets to B, so A wins the first tie. With both requesting, the port that is not `last` wins. A single requester always wins.
- Error check at acceptance: `addr[1:0]!=0` or `addr > MEM_BYTES-4` sets `err_q`.
- BUSY: if `!err_q`, drive `mem_addr` from the latched address. For a write, `mem_we=1` and `mem_wdata` = latched data. For a read, `mem_re=1` and `mem_rdata` is captured into the winner's rdata register at the end of the cycle. If `err_q`, no strobe is issued and rdata is set to 0. Go to RESP.
- RESP: pulse the winner's done, with err = `err_q`. rdata holds its value until the next read completion for that port. Go to IDLE.
- Requests are not sampled in BUSY or RESP. A losing requester keeps `req` high and is served in the next IDLE.
- `mem_we`/`mem_re` are decoded from the state register, so they are never high outside BUSY.
- Outputs after reset: gnt=0, done=0, err=0, rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, state=IDLE, last=B.

## Timing

- Request seen high at edge N (state IDLE): gnt is high in cycle N, BUSY in cycle N+1, done/err/rdata in cycle N+2, IDLE in cycle N+3.
- Memory writes commit at the edge that ends BUSY. A read in a later transaction sees that write.
- Throughput: one access per 3 cycles. Back-to-back requests from alternating ports are granted at N, N+3, N+6, and so on.
- Asserting `rst_n` low in BUSY drops `mem_we`/`mem_re` immediately. The write in progress is not guaranteed, and no done is issued.
- A `req` dropped before its grant is simply not served. No transaction is created.

## Configuration

- `DMEM_ARB_FIXED_PRIO_EN` defined: fixed priority. Port A always wins when both request, and the `last` register is not implemented. B can starve under continuous A traffic.
- Undefined (default): round-robin as described in Operation.

## Test plan

- Reset, then A writes 0xDEADBEEF to 0x100 and then reads 0x100: `mem_we` is high for exactly one cycle, and `a_done` arrives 2 cycles after each grant with `a_rdata=0xDEADBEEF` and `a_err=0`.
- A and B request in the same cycle, repeated 4 times: grants go A,B,A,B (default build), or A,A,A,A with `DMEM_ARB_FIXED_PRIO_EN`.
- B reads 0x102 (misaligned), then 0xFFFC (MEM_BYTES=65536), then 0x10000: results are err=1, err=0 (valid last word), err=1. No `mem_re` strobe on the errored accesses, and `b_rdata=0` on them.
- A writes to 0x200 and B reads 0x200, with both requesting together: A is served first, and B's done returns the new data.
- `rst_n` is pulsed low during BUSY of an A write: `mem_we` falls immediately, no `a_done` is issued, and all outputs return to reset values.
- B holds `req` for 10 cycles while A is idle: exactly one grant per 3 cycles (cycles 0, 3, 6, 9), each followed by done.
